// File: rtl/silife_gen_ctrl_pkg.sv
`default_nettype none
// silife_gen_ctrl_pkg -- register map, CTRL/STATUS bit indices and FSM encodings for the SiLife sequencer.
// rev 1.0
package silife_gen_ctrl_pkg;

    localparam logic [11:0] LOCAL_WINDOW  = 12'h000;
    localparam logic [11:0] MATRIX_WINDOW = 12'h001;

    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_PERIOD = 12'h004;
    localparam logic [11:0] REG_STEPS  = 12'h008;
    localparam logic [11:0] REG_GEN    = 12'h00C;
    localparam logic [11:0] REG_STATUS = 12'h010;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_STEP   = 1;
    localparam int CTRL_MAX_EN = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STATUS_DONE    = 0;
    localparam int STATUS_RUNNING = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/silife_gen_timer.sv
`default_nettype none
// silife_gen_timer -- reloading down-counter; tick while running and the count is zero.
// rev 1.0
module silife_gen_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] reload_val,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= reload_val;
        end else if (run) begin
            // reload_val is sampled here, so a new PERIOD lands at the next wrap
            if (count == '0) begin
                count <= reload_val;
            end else begin
                count <= count - PERIOD_W'(1);
            end
        end
    end

    assign tick = run && (count == '0);

endmodule
`default_nettype wire

// File: rtl/silife_gen_ctrl.sv
`default_nettype none
// silife_gen_ctrl -- Wishbone-controlled generation sequencer for the SiLife core.
// rev 1.0
module silife_gen_ctrl
    import silife_gen_ctrl_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int STEPS_W  = 16,
    parameter int GEN_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_mx_stb,
    input  logic        i_mx_ack,
    input  logic [31:0] i_mx_data,
    output logic        o_gen_tick,
    output logic        o_max7219_en,
    output logic        o_irq
);

    logic                local_sel;
    logic                mx_sel;
    logic [11:0]         offset;
    logic                access;
    logic                wr_ctrl;
    logic                wr_period;
    logic                wr_steps;
    logic                wr_gen;
    logic                wr_status;

    logic                ack_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rd_mux;
    logic                run_q;
    logic                max_en_q;
    logic                irq_en_q;
    logic [PERIOD_W-1:0] period_q;
    logic [STEPS_W-1:0]  steps_q;
    logic [GEN_W-1:0]    gen_q;
    logic                done_q;
    logic [1:0]          state_q;
    logic                gen_tick_q;

    logic [PERIOD_W-1:0] reload_val;
    logic                timer_tick;
    logic                start_run;
    logic                start_step;
    logic                stop_req;
    logic                fire;
    logic                finish;
    logic                unused_bits;

    assign unused_bits = ^{i_wb_addr[31:24], i_wb_data};

    assign offset    = i_wb_addr[11:0];
    assign local_sel = (i_wb_addr[23:12] == LOCAL_WINDOW);
    assign mx_sel    = (i_wb_addr[23:12] == MATRIX_WINDOW);

    // Blocking on ack_q keeps a held strobe from being acked on consecutive cycles
    assign access    = i_wb_cyc && i_wb_stb && local_sel && !ack_q;
    assign wr_ctrl   = access && i_wb_we && (offset == REG_CTRL);
    assign wr_period = access && i_wb_we && (offset == REG_PERIOD);
    assign wr_steps  = access && i_wb_we && (offset == REG_STEPS);
    assign wr_gen    = access && i_wb_we && (offset == REG_GEN);
    assign wr_status = access && i_wb_we && (offset == REG_STATUS);

    assign reload_val = (period_q == '0) ? '0 : (period_q - PERIOD_W'(1));

    assign start_run  = wr_ctrl && i_wb_data[CTRL_RUN] && (state_q == ST_IDLE);
    assign start_step = wr_ctrl && i_wb_data[CTRL_STEP] && !i_wb_data[CTRL_RUN]
                        && (state_q == ST_IDLE);
    assign stop_req   = wr_ctrl && !i_wb_data[CTRL_RUN];

    assign fire   = ((state_q == ST_RUN) && timer_tick && !stop_req) || (state_q == ST_STEP);
    assign finish = fire && (steps_q == STEPS_W'(1)) && !wr_steps;

    silife_gen_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (start_run),
        .run        (state_q == ST_RUN),
        .reload_val (reload_val),
        .tick       (timer_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_run) begin
                        state_q <= ST_RUN;
                    end else if (start_step) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (stop_req || finish) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STEP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q      <= 1'b0;
            max_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= PERIOD_W'(1);
            steps_q    <= '0;
            gen_q      <= '0;
            done_q     <= 1'b0;
            gen_tick_q <= 1'b0;
        end else begin
            gen_tick_q <= fire;

            if (finish) begin
                run_q <= 1'b0;
            end else if (wr_ctrl) begin
                run_q <= i_wb_data[CTRL_RUN];
            end
            if (wr_ctrl) begin
                max_en_q <= i_wb_data[CTRL_MAX_EN];
                irq_en_q <= i_wb_data[CTRL_IRQ_EN];
            end

            if (wr_period) begin
                period_q <= i_wb_data[PERIOD_W-1:0];
            end

            if (wr_steps) begin
                steps_q <= i_wb_data[STEPS_W-1:0];
            end else if (fire && (steps_q != '0)) begin
                steps_q <= steps_q - STEPS_W'(1);
            end

            if (wr_gen) begin
                gen_q <= '0;
            end else if (fire) begin
                gen_q <= gen_q + GEN_W'(1);
            end

            if (finish) begin
                done_q <= 1'b1;
            end else if (wr_status && i_wb_data[STATUS_DONE]) begin
                done_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            REG_CTRL: begin
                rd_mux[CTRL_RUN]    = run_q;
                rd_mux[CTRL_MAX_EN] = max_en_q;
                rd_mux[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_PERIOD: rd_mux[PERIOD_W-1:0] = period_q;
            REG_STEPS:  rd_mux[STEPS_W-1:0]  = steps_q;
            REG_GEN:    rd_mux[GEN_W-1:0]    = gen_q;
            REG_STATUS: begin
                rd_mux[STATUS_DONE]    = done_q;
                rd_mux[STATUS_RUNNING] = (state_q == ST_RUN);
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= access;
            if (access && !i_wb_we) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign o_mx_stb     = i_wb_stb && mx_sel;
    assign o_wb_ack     = mx_sel ? i_mx_ack : ack_q;
    assign o_wb_data    = mx_sel ? i_mx_data : rdata_q;
    assign o_gen_tick   = gen_tick_q;
    assign o_max7219_en = max_en_q;
    assign o_irq        = done_q && irq_en_q;

endmodule
`default_nettype wire
